// File: rtl/seq_detect_display.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_display
//  Purpose  : Serial pattern detector (strobe-accepted bits) feeding a BCD
//             match counter, scanned onto a common-anode seven-segment
//             display with one-hot active-low digit selects.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_display #(
    parameter int                   DIGITS   = 4,
    parameter int                   PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN  = 4'b1101,
    parameter int                   OVERLAP  = 1,
    parameter int                   SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key,
    input  logic              res_en,
    input  logic              clr,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        data,
    output logic              match
);

    localparam int                 FILL_W    = $clog2(PAT_LEN + 1);
    localparam int                 PRE_W     = $clog2(SCAN_DIV);
    localparam int                 IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DIGITS - 1);

    // Segment code {g,f,e,d,c,b,a}, active-low; non-BCD values blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic                  res_q;
    logic                  accept;
    logic [PAT_LEN-1:0]    shift_q, shift_d, shift_nx;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_nx;
    logic                  hit;
    logic                  match_q;
    logic [4*DIGITS-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                  ovf_q, ovf_d;
    logic                  inc_carry;
    logic [3:0]            inc_dig;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            cur_dig;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic [7:0]            data_q, data_d;

    // Strobe edge detect, history shift and fill level (fill level is the FSM state).
    always_comb begin
        accept   = res_en & ~res_q;
        shift_nx = {shift_q[PAT_LEN-2:0], key};
        fill_nx  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        hit      = accept && (fill_nx == FILL_FULL) && (shift_nx == PATTERN);
        shift_d  = shift_q;
        fill_d   = fill_q;
        if (accept) begin
            if (hit && (OVERLAP == 0)) begin
                shift_d = '0;
                fill_d  = '0;
            end else begin
                shift_d = shift_nx;
                fill_d  = fill_nx;
            end
        end
    end

    // BCD increment with decimal carry; a carry out of the top digit means wrap.
    always_comb begin
        cnt_inc   = cnt_q;
        inc_carry = 1'b1;
        inc_dig   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            inc_dig = cnt_q[4*i +: 4];
            if (inc_carry) begin
                if (inc_dig == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = inc_dig + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (hit) begin
            cnt_d = cnt_inc;
            if (inc_carry) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Scan prescaler, digit index and the registered select/segment images.
    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        cur_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig = cnt_q[4*i +: 4];
            end
        end
        sel_d  = ~(DIGITS'(1) << idx_q);
        data_d = {~(ovf_q && (idx_q == IDX_LAST)), seg7(cur_dig)};
    end

    // State registers; reset is asynchronous so the display blanks to "0" at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= 1'b0;
            shift_q <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            sel_q   <= ~DIGITS'(1);
            data_q  <= 8'hC0;
        end else begin
            res_q   <= res_en;
            shift_q <= shift_d;
            fill_q  <= fill_d;
            match_q <= hit;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign sel   = sel_q;
    assign data  = data_q;
    assign match = match_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_display
//  Purpose  : Directed bench for seq_detect_display. Three instances share the
//             stimulus: A = defaults with fast scan, B = non-overlapping,
//             C = two digits with fast scan (overflow).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_display;

    logic       clk;
    logic       rst;
    logic       key;
    logic       res_en;
    logic       clr;
    logic [3:0] sel_a;
    logic [7:0] data_a;
    logic       match_a;
    logic [3:0] sel_b;
    logic [7:0] data_b;
    logic       match_b;
    logic [1:0] sel_c;
    logic [7:0] data_c;
    logic       match_c;

    int n_vec = 0;
    int n_err = 0;

    seq_detect_display #(.SCAN_DIV(4)) u_a (
        .clk(clk), .rst(rst), .key(key), .res_en(res_en), .clr(clr),
        .sel(sel_a), .data(data_a), .match(match_a)
    );

    seq_detect_display #(.OVERLAP(0)) u_b (
        .clk(clk), .rst(rst), .key(key), .res_en(res_en), .clr(clr),
        .sel(sel_b), .data(data_b), .match(match_b)
    );

    seq_detect_display #(.DIGITS(2), .SCAN_DIV(4)) u_c (
        .clk(clk), .rst(rst), .key(key), .res_en(res_en), .clr(clr),
        .sel(sel_c), .data(data_c), .match(match_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One strobed bit; returns {C,B,A} match sampled the cycle after the accept.
    task automatic strobe(input logic b, output logic [2:0] m);
        key    = b;
        res_en = 1'b1;
        @(negedge clk);
        m      = {match_c, match_b, match_a};
        res_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic get_digit(input int inst, input int k, output logic [7:0] d);
        bit found;
        found = 1'b0;
        d     = 8'hxx;
        for (int t = 0; t < 5000 && !found; t++) begin
            @(negedge clk);
            if (inst == 0 && sel_a == ~(4'b0001 << k)) begin
                found = 1'b1;
                d     = data_a;
            end else if (inst == 1 && sel_b == ~(4'b0001 << k)) begin
                found = 1'b1;
                d     = data_b;
            end else if (inst == 2 && sel_c == ~(2'b01 << k)) begin
                found = 1'b1;
                d     = data_c;
            end
        end
    endtask

    task automatic chk_digit(input string tag, input int inst, input int k, input logic [7:0] exp);
        logic [7:0] d;
        get_digit(inst, k, d);
        check(tag, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic wait_sel_a(input logic [3:0] s, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (sel_a == s) ok = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [6:0] stream;
    logic [6:0] exp_ma;
    logic [6:0] exp_mb;
    logic [2:0] m;
    int         mcount;
    bit         ok;

    initial begin
        rst    = 1'b1;
        key    = 1'b0;
        res_en = 1'b0;
        clr    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_match", {31'd0, match_a}, 32'd0);
        check("rst_sel_a", {28'd0, sel_a}, 32'hE);
        check("rst_data_a", {24'd0, data_a}, 32'hC0);
        check("rst_sel_c", {30'd0, sel_c}, 32'h2);
        check("rst_data_c", {24'd0, data_c}, 32'hC0);
        rst = 1'b0;
        @(negedge clk);

        // Stream 1,1,0,1,1,0,1: overlap hits on 4th and 7th, non-overlap on 4th only
        stream = 7'b1101101;
        exp_ma = 7'b0001001;
        exp_mb = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            strobe(stream[6-i], m);
            check($sformatf("ovl_match_%0d", i + 1), {31'd0, m[0]}, {31'd0, exp_ma[6-i]});
            check($sformatf("novl_match_%0d", i + 1), {31'd0, m[1]}, {31'd0, exp_mb[6-i]});
            if (i == 3) check("match_one_cycle", {31'd0, match_a}, 32'd0);
        end

        chk_digit("a_dig0_two", 0, 0, 8'hA4);
        chk_digit("a_dig1_zero", 0, 1, 8'hC0);
        chk_digit("a_dig2_zero", 0, 2, 8'hC0);
        chk_digit("a_dig3_zero", 0, 3, 8'hC0);
        chk_digit("b_dig0_one", 1, 0, 8'hF9);
        chk_digit("c_dig0_two", 2, 0, 8'hA4);

        // Held strobe: only the first bit (0) may enter; toggling key would otherwise form 1101
        pulse_reset();
        strobe(1'b1, m);
        strobe(1'b1, m);
        key    = 1'b0;
        res_en = 1'b1;
        mcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (match_a) mcount++;
            key = ~key;
        end
        res_en = 1'b0;
        @(negedge clk);
        if (match_a) mcount++;
        check("hold_no_extra_accept", mcount, 32'd0);
        strobe(1'b1, m);
        check("rearm_accepts_bit", {31'd0, m[0]}, 32'd1);

        // Scan order, each digit held four cycles
        wait_sel_a(4'b1110, ok);
        check("scan_sync0", {31'd0, ok}, 32'd1);
        wait_sel_a(4'b1101, ok);
        check("scan_sync1", {31'd0, ok}, 32'd1);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("scan_%0d", j), {28'd0, sel_a}, {28'd0, ~(4'b0001 << ((1 + j / 4) % 4))});
            @(negedge clk);
        end

        // 100 matches: C wraps 99->00 with ovf, A reads 0100
        pulse_reset();
        strobe(1'b1, m);
        strobe(1'b1, m);
        strobe(1'b0, m);
        strobe(1'b1, m);
        for (int i = 0; i < 99; i++) begin
            strobe(1'b1, m);
            strobe(1'b0, m);
            strobe(1'b1, m);
        end
        chk_digit("c_ovf_dp", 2, 1, 8'h40);
        chk_digit("c_ovf_dig0", 2, 0, 8'hC0);
        chk_digit("a_100_dig2", 0, 2, 8'hF9);
        chk_digit("a_100_dig0", 0, 0, 8'hC0);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk_digit("c_clr_dig1", 2, 1, 8'hC0);
        chk_digit("c_clr_dig0", 2, 0, 8'hC0);

        // clr on the same edge as a match: counter stays 0, match still pulses
        strobe(1'b1, m);
        strobe(1'b0, m);
        key    = 1'b1;
        res_en = 1'b1;
        clr    = 1'b1;
        @(negedge clk);
        check("clr_match_pulse", {31'd0, match_a}, 32'd1);
        clr    = 1'b0;
        res_en = 1'b0;
        @(negedge clk);
        chk_digit("clr_match_a_dig0", 0, 0, 8'hC0);
        chk_digit("clr_match_c_dig0", 2, 0, 8'hC0);

        // Asynchronous reset between clock edges
        wait_sel_a(4'b0111, ok);
        check("async_sync", {31'd0, ok}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_sel", {28'd0, sel_a}, 32'hE);
        check("async_data", {24'd0, data_a}, 32'hC0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
